pipe_hazard_ctrl: RTL and testbench

Central stall/flush and memory-port controller for the 5-stage RISC-V pipeline.
- Arbitrates the single shared memory-controller port between instruction fetch (IF) and the load/store stage (MEM).
- Generates per-stage stall, bubble and flush controls consumed by pc_reg, if_id, id_ex and ex_mem.
- Keeps a saturating stall-cycle counter for performance debug.

---
 rtl/pipe_hazard_ctrl_if.sv | 40 ++++
 rtl/pipe_hazard_ctrl.sv | 125 ++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// Handshake bundle between the pipeline stages and the hazard/port controller.
// master = pipeline side, slave = controller side.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             if_req;
  logic             mem_req;
  logic             mc_done;
  logic             mc_start;
  logic             mc_sel;
  logic             if_done;
  logic             mem_done;
  logic             id_stall_req;
  logic             ex_branch_taken;
  logic             pc_stall;
  logic             ifid_stall;
  logic             ifid_bubble;
  logic             idex_stall;
  logic             exmem_stall;
  logic             branch_interception;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output if_req, mem_req, mc_done,
    output id_stall_req, ex_branch_taken,
    input  mc_start, mc_sel, if_done, mem_done,
    input  pc_stall, ifid_stall, ifid_bubble,
    input  idex_stall, exmem_stall,
    input  branch_interception, stall_cnt
  );

  modport slave (
    input  if_req, mem_req, mc_done,
    input  id_stall_req, ex_branch_taken,
    output mc_start, mc_sel, if_done, mem_done,
    output pc_stall, ifid_stall, ifid_bubble,
    output idex_stall, exmem_stall,
    output branch_interception, stall_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Shared memory-port arbiter plus stall/flush generation for the 5-stage pipe.
// Also keeps a saturating count of PC stall cycles.
module pipe_hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input logic              clk,
  input logic              rst,
  pipe_hazard_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    IF_BUSY,
    MEM_BUSY
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic             disc_q;
  logic             disc_d;
  logic             sel_q;
  logic [CNT_W-1:0] cnt_q;

  logic start_mem;
  logic start_if;
  logic sel;
  logic if_dn;
  logic mem_dn;
  logic mem_wait;
  logic br_int;
  logic ifid_st;
  logic pc_st;
  logic bub;
  logic in_if;
  logic in_mem;

  assign in_if  = (state_q == IF_BUSY);
  assign in_mem = (state_q == MEM_BUSY);

  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (bus.mem_req)     state_d = MEM_BUSY;
        else if (bus.if_req) state_d = IF_BUSY;
      end
      IF_BUSY,
      MEM_BUSY: begin
        if (bus.mc_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    start_mem = 1'b0;
    start_if  = 1'b0;
    sel       = sel_q;
    if_dn     = 1'b0;
    mem_dn    = 1'b0;
    unique case (state_q)
      IDLE: begin
        start_mem = bus.mem_req;
        start_if  = ~bus.mem_req & bus.if_req;
        if (start_mem)     sel = 1'b1;
        else if (start_if) sel = 1'b0;
      end
      IF_BUSY: begin
        sel   = 1'b0;
        // a fetch on the stale PC never reaches if_id
        if_dn = bus.mc_done & ~disc_q & ~br_int;
      end
      MEM_BUSY: begin
        sel    = 1'b1;
        mem_dn = bus.mc_done;
      end
      default: ;
    endcase
  end

  assign mem_wait = bus.mem_req & ~(in_mem & bus.mc_done);
  assign br_int   = bus.ex_branch_taken & ~mem_wait;
  assign ifid_st  = mem_wait | (bus.id_stall_req & ~br_int);
  assign pc_st    = ~br_int & (ifid_st | ~if_dn);
  assign bub      = ~if_dn & ~ifid_st;

  always_comb begin
    disc_d = disc_q;
    if (br_int & ((in_if & ~bus.mc_done) | start_if))
      disc_d = 1'b1;
    else if (in_if & bus.mc_done)
      disc_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      disc_q <= 1'b0;
      sel_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      disc_q <= disc_d;
      sel_q  <= sel;
      if (pc_st && cnt_q != '1)
        cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign bus.mc_start            = rst & (start_mem | start_if);
  assign bus.mc_sel              = rst & sel;
  assign bus.if_done             = rst & if_dn;
  assign bus.mem_done            = rst & mem_dn;
  assign bus.pc_stall            = rst & pc_st;
  assign bus.ifid_stall          = rst & ifid_st;
  assign bus.ifid_bubble         = rst & bub;
  assign bus.idex_stall          = rst & mem_wait;
  assign bus.exmem_stall         = rst & mem_wait;
  assign bus.branch_interception = rst & br_int;
  assign bus.stall_cnt           = rst ? cnt_q : '0;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized check of pipe_hazard_ctrl against a transaction-level model.
// A second instance with a 4-bit counter exercises saturation.
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic if_req;
  logic mem_req;
  logic mc_done;
  logic idsr;
  logic br;

  pipe_hazard_ctrl_if #(.CNT_W(32)) bus ();
  pipe_hazard_ctrl_if #(.CNT_W(4))  sbus ();

  assign bus.if_req           = if_req;
  assign bus.mem_req          = mem_req;
  assign bus.mc_done          = mc_done;
  assign bus.id_stall_req     = idsr;
  assign bus.ex_branch_taken  = br;
  assign sbus.if_req          = if_req;
  assign sbus.mem_req         = mem_req;
  assign sbus.mc_done         = mc_done;
  assign sbus.id_stall_req    = idsr;
  assign sbus.ex_branch_taken = br;

  pipe_hazard_ctrl #(.CNT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  pipe_hazard_ctrl #(.CNT_W(4)) dut_s (
    .clk (clk),
    .rst (rst),
    .bus (sbus)
  );

  int n_run  = 0;
  int n_fail = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // model: who owns the port (0 none, 1 fetch, 2 load/store)
  int          owner;
  bit          disc;
  bit          last_sel;
  longint      cnt;
  longint      cnt_s;
  bit          mem_pend;

  task automatic model_reset();
    owner    = 0;
    disc     = 0;
    last_sel = 0;
    cnt      = 0;
    cnt_s    = 0;
  endtask

  task automatic cycle();
    int  start;
    bit  mw, bi, e_st, e_sel, e_ifd, e_memd;
    bit  e_ifs, e_pcs, e_bub;
    longint e_cnt, e_cnts;
    #1;
    mw     = mem_req && !(owner == 2 && mc_done);
    bi     = br && !mw;
    start  = 0;
    if (owner == 0) start = mem_req ? 2 : (if_req ? 1 : 0);
    e_st   = (start != 0);
    if (owner == 1)      e_sel = 0;
    else if (owner == 2) e_sel = 1;
    else if (start == 2) e_sel = 1;
    else if (start == 1) e_sel = 0;
    else                 e_sel = last_sel;
    e_ifd  = (owner == 1) && mc_done && !disc && !bi;
    e_memd = (owner == 2) && mc_done;
    e_ifs  = mw || (idsr && !bi);
    e_pcs  = !bi && (e_ifs || !e_ifd);
    e_bub  = !e_ifd && !e_ifs;
    e_cnt  = cnt;
    e_cnts = cnt_s;
    if (!rst) begin
      e_st = 0; e_sel = 0; e_ifd = 0; e_memd = 0;
      e_ifs = 0; e_pcs = 0; e_bub = 0; mw = 0; bi = 0;
      e_cnt = 0; e_cnts = 0;
    end
    chk("mc_start",  64'(bus.mc_start),            64'(e_st));
    chk("mc_sel",    64'(bus.mc_sel),              64'(e_sel));
    chk("if_done",   64'(bus.if_done),             64'(e_ifd));
    chk("mem_done",  64'(bus.mem_done),            64'(e_memd));
    chk("pc_stall",  64'(bus.pc_stall),            64'(e_pcs));
    chk("ifid_stl",  64'(bus.ifid_stall),          64'(e_ifs));
    chk("ifid_bub",  64'(bus.ifid_bubble),         64'(e_bub));
    chk("idex_stl",  64'(bus.idex_stall),          64'(mw));
    chk("exmem_stl", 64'(bus.exmem_stall),         64'(mw));
    chk("br_int",    64'(bus.branch_interception), 64'(bi));
    chk("stall_cnt", 64'(bus.stall_cnt),           64'(e_cnt));
    chk("cnt4",      64'(sbus.stall_cnt),          64'(e_cnts));
    @(posedge clk);
    if (!rst) begin
      model_reset();
      mem_pend = 0;
    end else begin
      if (e_memd) mem_pend = 0;
      if (start != 0)
        owner = start;
      else if (owner != 0 && mc_done)
        owner = 0;
      if (bi && ((e_sel == 0 && owner == 1 && start == 0 && !mc_done)
                 || start == 1))
        disc = 1;
      else if (e_ifd || (e_sel == 0 && !e_st && mc_done && !e_memd))
        disc = (owner == 1) ? disc : 0;
      last_sel = e_sel;
      if (e_pcs) begin
        if (cnt != 64'hFFFF_FFFF) cnt++;
        if (cnt_s != 15) cnt_s++;
      end
    end
    @(negedge clk);
  endtask

  // discard bit kept explicitly: a branch while a fetch is in flight (or
  // launching) spoils that fetch; the fetch's completion clears it
  bit fetch_live;

  task automatic drive(input bit r, input bit ir, input bit mr,
                       input bit md, input bit sr, input bit b);
    rst = r; if_req = ir; mem_req = mr;
    mc_done = md; idsr = sr; br = b;
  endtask

  task automatic drive_rand();
    if (!mem_pend) mem_pend = ($urandom_range(0, 3) == 0);
    drive($urandom_range(0, 49) != 0,
          $urandom_range(0, 9) < 7,
          mem_pend,
          $urandom_range(0, 2) == 0,
          $urandom_range(0, 4) == 0,
          $urandom_range(0, 4) == 0);
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    mem_pend = 1;
    model_reset();
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, $urandom_range(0, 1) == 1, 1'b1, 1'b1, 1'b1, 1'b1);
      cycle();
    end
    mem_pend = 1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 1'b1, i == 3, 1'b0, 1'b0);
      cycle();
    end
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, i == 5);
      cycle();
    end
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle();
    for (int i = 0; i < 4000; i++) begin
      drive_rand();
      cycle();
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
